command_sequencer: RTL and testbench

// Sequences 24-bit command words into the control_matrix soft-CPU datapath. Holds a small

---
 rtl/command_sequencer_if.sv | 45 ++++
 rtl/command_sequencer.sv | 163 ++++++++++++++++
 tb/tb_command_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/command_sequencer_if.sv
`timescale 1ns/1ps
// command_sequencer_if
// Bundles the board-side control inputs, the datapath ACC return and the
// sequencer outputs toward control_matrix into one connection.
//
// Handshake: cmd_valid is a one-cycle strobe with no ready. It is high for
// exactly the first cycle in which cmd_out carries a newly issued command.
// cmd_out then stays stable until the next strobe. It also stays stable
// through HALT and IDLE, and only reset clears it.
//
// Signals
//   load_en/load_addr/load_data  program memory write port (master -> slave)
//   run/step/rewind              execution control levels  (master -> slave)
//   acc_in                       ACC from control_matrix     (master -> slave)
//   cmd_out/cmd_valid            command word + new-command strobe (slave -> master)
//   pc/result/busy/halted        status                      (slave -> master)
//   dbg_state                    raw FSM state encoding      (slave -> master)
interface command_sequencer_if #(
    parameter int AW = 3
);
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [23:0]   load_data;
    logic          run;
    logic          step;
    logic          rewind;
    logic [7:0]    acc_in;
    logic [23:0]   cmd_out;
    logic          cmd_valid;
    logic [AW-1:0] pc;
    logic [7:0]    result;
    logic          busy;
    logic          halted;
    logic [2:0]    dbg_state;

    modport master (
        output load_en, load_addr, load_data, run, step, rewind, acc_in,
        input  cmd_out, cmd_valid, pc, result, busy, halted, dbg_state
    );

    modport slave (
        input  load_en, load_addr, load_data, run, step, rewind, acc_in,
        output cmd_out, cmd_valid, pc, result, busy, halted, dbg_state
    );
endinterface

// File: rtl/command_sequencer.sv
`timescale 1ns/1ps
// command_sequencer
// Feeds 24-bit command words from a small loadable program memory into the
// control_matrix datapath, one at a time. Each command is issued and held for
// EXEC_CYCLES settle cycles. The datapath ACC is then captured into result.
// The sequencer stops on a HALT_OP opcode or after the last memory word.
//
// Ports
//   clock    rising-edge system clock
//   reset_n  asynchronous active-low reset. Program memory is not reset.
//   bus      command_sequencer_if.slave. It carries the load port,
//            run/step/rewind, acc_in, cmd_out/cmd_valid, pc, result,
//            busy, halted and dbg_state. dbg_state uses the encoding
//            IDLE=0 FETCH=1 ISSUE=2 WAIT=3 CAPTURE=4 HALT=5.
//
// The bus interface instance must use the same AW as this module.
module command_sequencer #(
    parameter int         AW          = 3,
    parameter int         EXEC_CYCLES = 2,
    parameter logic [5:0] HALT_OP     = 6'b111111
) (
    input logic                clock,
    input logic                reset_n,
    command_sequencer_if.slave bus
);
    localparam int            DEPTH     = 2 ** AW;
    localparam logic [AW-1:0] PC_LAST   = {AW{1'b1}};
    localparam logic [3:0]    WAIT_LAST = 4'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [23:0]   cmd_reg;
    logic [23:0]   cmd_out;
    logic          cmd_valid;
    logic [7:0]    result;
    logic          busy;
    logic          halted;
    logic [3:0]    wait_cnt;
    logic          run_mode;

    logic [23:0]   mem [DEPTH];

    // Loads are accepted only while idle or halted.
    // Loads take priority over run/step/rewind in the same cycle.
    logic load_ok;
    assign load_ok = bus.load_en && (state == S_IDLE || state == S_HALT);

    // The program memory has no reset, so a program survives a reset pulse.
    always_ff @(posedge clock) begin
        if (load_ok) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            cmd_reg   <= '0;
            cmd_out   <= '0;
            cmd_valid <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            wait_cnt  <= '0;
            run_mode  <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.load_en) begin
                        // The memory write happens in the memory block.
                        // This state does not change.
                    end else if (bus.rewind) begin
                        pc <= '0;
                    end else if (bus.run || bus.step) begin
                        run_mode <= bus.run;   // run wins when both are high
                        busy     <= 1'b1;
                        state    <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    cmd_reg <= mem[pc];
                    if (mem[pc][23:18] == HALT_OP) begin
                        // A halt word is never issued.
                        // pc stays on it until rewind.
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    cmd_out   <= cmd_reg;
                    cmd_valid <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (wait_cnt == WAIT_LAST) begin
                        state <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    result <= bus.acc_in;
                    if (pc == PC_LAST) begin
                        // The last word has run. pc wraps now, so a rewind
                        // from HALT changes nothing further.
                        pc     <= '0;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        pc <= pc + AW'(1);
                        if (run_mode) begin
                            state <= S_FETCH;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end

                S_HALT: begin
                    if (!bus.load_en && bus.rewind) begin
                        pc     <= '0;
                        halted <= 1'b0;
                        state  <= S_IDLE;
                    end
                end

                default: begin
                    busy   <= 1'b0;
                    halted <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_out   = cmd_out;
    assign bus.cmd_valid = cmd_valid;
    assign bus.pc        = pc;
    assign bus.result    = result;
    assign bus.busy      = busy;
    assign bus.halted    = halted;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_command_sequencer.sv
`timescale 1ns/1ps
module tb_command_sequencer;
    localparam int AW = 3;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd5;

    logic clock;
    logic reset_n;

    command_sequencer_if #(.AW(AW)) bus ();

    command_sequencer #(
        .AW(AW),
        .EXEC_CYCLES(2),
        .HALT_OP(6'b111111)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard
    logic [23:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          pulses   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Every cmd_valid strobe must match the next expected command word.
    always @(negedge clock) begin
        if (reset_n && bus.cmd_valid) begin
            pulses++;
            if (exp_q.size() == 0) check("cmd_unexpected", 32'd1, 32'd0);
            else check("cmd_scoreboard", {8'h0, bus.cmd_out}, {8'h0, exp_q.pop_front()});
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load_word(input logic [AW-1:0] addr, input logic [23:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        tick(1);
        bus.load_en   = 1'b0;
    endtask

    task automatic pulse_run();
        bus.run = 1'b1;
        tick(1);
        bus.run = 1'b0;
    endtask

    task automatic pulse_step();
        bus.step = 1'b1;
        tick(1);
        bus.step = 1'b0;
    endtask

    task automatic pulse_rewind();
        bus.rewind = 1'b1;
        tick(1);
        bus.rewind = 1'b0;
    endtask

    initial begin
        int p0;
        int guard;
        reset_n       = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.run       = 1'b0;
        bus.step      = 1'b0;
        bus.rewind    = 1'b0;
        bus.acc_in    = 8'h00;
        tick(2);
        check("rst_state",  32'(bus.dbg_state), 32'(ST_IDLE));
        check("rst_pc",     32'(bus.pc), 32'd0);
        check("rst_cmd",    32'(bus.cmd_out), 32'd0);
        check("rst_valid",  32'(bus.cmd_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        reset_n = 1'b1;
        tick(1);

        // 1: run a two-command program that ends on a halt word
        load_word(3'd0, 24'h082A01);
        load_word(3'd1, 24'h082A02);
        load_word(3'd2, 24'hFC0000);
        exp_q.push_back(24'h082A01);
        exp_q.push_back(24'h082A02);
        p0 = pulses;
        pulse_run();
        check("t1_fetch", 32'(bus.dbg_state), 32'(ST_FETCH));
        check("t1_busy",  32'(bus.busy), 32'd1);
        tick(2);
        check("t1_valid0", 32'(bus.cmd_valid), 32'd1);
        check("t1_cmd0",   32'(bus.cmd_out), 32'h082A01);
        tick(2);
        bus.acc_in = 8'h5A;
        tick(1);
        check("t1_res0", 32'(bus.result), 32'h5A);
        tick(2);
        check("t1_valid1", 32'(bus.cmd_valid), 32'd1);
        check("t1_cmd1",   32'(bus.cmd_out), 32'h082A02);
        bus.acc_in = 8'hA5;
        tick(3);
        check("t1_res1", 32'(bus.result), 32'hA5);
        tick(1);
        check("t1_halted", 32'(bus.halted), 32'd1);
        check("t1_busy0",  32'(bus.busy), 32'd0);
        check("t1_pc",     32'(bus.pc), 32'd2);
        check("t1_cmdkeep", 32'(bus.cmd_out), 32'h082A02);
        check("t1_pulses", 32'(pulses - p0), 32'd2);
        pulse_run();
        tick(2);
        check("t1_run_ignored", 32'(bus.dbg_state), 32'(ST_HALT));
        pulse_rewind();
        check("t1_rew_state",  32'(bus.dbg_state), 32'(ST_IDLE));
        check("t1_rew_halted", 32'(bus.halted), 32'd0);
        check("t1_rew_pc",     32'(bus.pc), 32'd0);

        // 2: one step executes one command
        bus.acc_in = 8'h3C;
        exp_q.push_back(24'h082A01);
        p0 = pulses;
        pulse_step();
        tick(4);
        check("t2_res_early", 32'(bus.result), 32'hA5);
        tick(1);
        check("t2_res",    32'(bus.result), 32'h3C);
        check("t2_pc",     32'(bus.pc), 32'd1);
        check("t2_idle",   32'(bus.dbg_state), 32'(ST_IDLE));
        tick(3);
        check("t2_pulses", 32'(pulses - p0), 32'd1);

        // 3: a halt word at pc 0 is never issued
        pulse_rewind();
        load_word(3'd0, 24'hFC0000);
        p0 = pulses;
        pulse_run();
        check("t3_halted_early", 32'(bus.halted), 32'd0);
        tick(1);
        check("t3_halted", 32'(bus.halted), 32'd1);
        check("t3_pc",     32'(bus.pc), 32'd0);
        check("t3_cmdkeep", 32'(bus.cmd_out), 32'h082A01);
        tick(3);
        check("t3_pulses", 32'(pulses - p0), 32'd0);

        // 4: eight non-halt words, execution stops after the last address
        pulse_rewind();
        for (int i = 0; i < 8; i++) begin
            load_word(3'(i), 24'h010000 + 24'(i));
            exp_q.push_back(24'h010000 + 24'(i));
        end
        bus.acc_in = 8'h77;
        p0 = pulses;
        pulse_run();
        guard = 0;
        while (!bus.halted && guard < 100) begin
            tick(1);
            guard++;
        end
        check("t4_halted", 32'(bus.halted), 32'd1);
        check("t4_pulses", 32'(pulses - p0), 32'd8);
        check("t4_pc",     32'(bus.pc), 32'd0);
        check("t4_res",    32'(bus.result), 32'h77);
        pulse_rewind();
        check("t4_rew_state",  32'(bus.dbg_state), 32'(ST_IDLE));
        check("t4_rew_halted", 32'(bus.halted), 32'd0);

        // 5: a load while busy is dropped; load and run together in IDLE stores and does not start
        exp_q.push_back(24'h010000);
        pulse_step();
        tick(3);
        check("t5_in_wait", 32'(bus.dbg_state), 32'(ST_WAIT));
        load_word(3'd1, 24'h123456);
        tick(1);
        check("t5_pc1", 32'(bus.pc), 32'd1);
        exp_q.push_back(24'h010001);
        pulse_step();
        tick(2);
        check("t5_cmd_mem1", 32'(bus.cmd_out), 32'h010001);
        tick(3);
        check("t5_pc2", 32'(bus.pc), 32'd2);
        bus.run = 1'b1;
        load_word(3'd2, 24'h0A0B0C);
        bus.run = 1'b0;
        check("t5_run_ignored", 32'(bus.dbg_state), 32'(ST_IDLE));
        check("t5_busy", 32'(bus.busy), 32'd0);
        exp_q.push_back(24'h0A0B0C);
        pulse_step();
        tick(5);
        check("t5_pc3", 32'(bus.pc), 32'd3);

        // 6: asynchronous reset in WAIT, then the memory is still intact
        pulse_rewind();
        exp_q.push_back(24'h010000);
        pulse_step();
        tick(3);
        check("t6_in_wait", 32'(bus.dbg_state), 32'(ST_WAIT));
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_state",  32'(bus.dbg_state), 32'(ST_IDLE));
        check("t6_rst_cmd",    32'(bus.cmd_out), 32'd0);
        check("t6_rst_result", 32'(bus.result), 32'd0);
        check("t6_rst_busy",   32'(bus.busy), 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        exp_q.push_back(24'h010000);
        pulse_step();
        tick(2);
        check("t6_cmd", 32'(bus.cmd_out), 32'h010000);
        tick(3);
        check("t6_pc", 32'(bus.pc), 32'd1);

        tick(2);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
